// File: rtl/dpll_pkg.sv
// Shared types and default constants for the DPKD digital PLL phase path.
// Optional lock detection is enabled with PHASE_LOCK_DETECT_EN.
package dpll_pkg;

  typedef enum logic [1:0] {IDLE, WAIT_FB, WAIT_REF} pd_state_t;
  typedef enum logic [1:0] {VOTE_NONE, VOTE_LAG, VOTE_LEAD} pd_vote_t;

  localparam int DEF_FILTER_N   = 8;
  localparam int DEF_MAX_WINDOW = 64;
  localparam int DEF_LOCK_TOL   = 1;
  localparam int DEF_LOCK_COUNT = 16;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer, history flop and registered rising-edge strobe.
// Latency is fixed so that two instances preserve relative phase.
module sync_edge_det (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic rise_o
);

  logic [2:0] sr;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sr     <= '0;
      rise_o <= 1'b0;
    end else begin
      sr     <= {sr[1:0], d_i};
      rise_o <= sr[1] & ~sr[2];
    end
  end

endmodule

// File: rtl/phase_shift_ctrl.sv
// Bang-bang phase detector and random-walk filter driving divider shift pulses.
// Define PHASE_LOCK_DETECT_EN to add the lock counter and lock_o port.
//
// state    | meaning
// IDLE     | no edge pending; coincident edges are an in-phase comparison
// WAIT_FB  | reference edge seen, counting cycles until feedback edge
// WAIT_REF | feedback edge seen, counting cycles until reference edge
module phase_shift_ctrl
  import dpll_pkg::*;
#(
  parameter int FILTER_N   = DEF_FILTER_N,
  parameter int MAX_WINDOW = DEF_MAX_WINDOW
`ifdef PHASE_LOCK_DETECT_EN
  ,
  parameter int LOCK_TOL   = DEF_LOCK_TOL,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT
`endif
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic ref_i,
  input  logic fb_i,
  output logic positiveShift_o,
  output logic negativeShift_o
`ifdef PHASE_LOCK_DETECT_EN
  ,
  output logic lock_o
`endif
);

  localparam int AW = $clog2(FILTER_N) + 1;
  localparam int WW = $clog2(MAX_WINDOW);
  localparam logic signed [AW-1:0] ACC_MAX = AW'(FILTER_N - 1);
  localparam logic signed [AW-1:0] ACC_MIN = -ACC_MAX;
  localparam logic [WW-1:0] WIN_LAST = WW'(MAX_WINDOW - 1);

  logic ref_e, fb_e;
  pd_state_t state;
  logic [WW-1:0] win;
  logic signed [AW-1:0] acc;
  pd_vote_t vote;
  logic timeout;

  sync_edge_det u_ref_sync (.clk_i(clk_i), .reset_i(reset_i), .d_i(ref_i), .rise_o(ref_e));
  sync_edge_det u_fb_sync  (.clk_i(clk_i), .reset_i(reset_i), .d_i(fb_i),  .rise_o(fb_e));

  // Partner edge always wins over a same-source restart or a timeout.
  always_comb begin
    vote    = VOTE_NONE;
    timeout = 1'b0;
    case (state)
      WAIT_FB: begin
        if (fb_e) vote = VOTE_LAG;
        else if (!ref_e && win == WIN_LAST) timeout = 1'b1;
      end
      WAIT_REF: begin
        if (ref_e) vote = VOTE_LEAD;
        else if (!fb_e && win == WIN_LAST) timeout = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state           <= IDLE;
      win             <= '0;
      acc             <= '0;
      positiveShift_o <= 1'b0;
      negativeShift_o <= 1'b0;
    end else begin
      positiveShift_o <= 1'b0;
      negativeShift_o <= 1'b0;

      case (state)
        IDLE: begin
          win <= '0;
          if (ref_e && !fb_e)      state <= WAIT_FB;
          else if (fb_e && !ref_e) state <= WAIT_REF;
        end
        WAIT_FB: begin
          if (fb_e)         state <= IDLE;
          else if (ref_e)   win   <= '0;
          else if (timeout) state <= IDLE;
          else              win   <= win + WW'(1);
        end
        WAIT_REF: begin
          if (ref_e)        state <= IDLE;
          else if (fb_e)    win   <= '0;
          else if (timeout) state <= IDLE;
          else              win   <= win + WW'(1);
        end
        default: state <= IDLE;
      endcase

      case (vote)
        VOTE_LAG: begin
          if (acc == ACC_MAX) begin
            acc             <= '0;
            positiveShift_o <= 1'b1;
          end else begin
            acc <= acc + AW'(1);
          end
        end
        VOTE_LEAD: begin
          if (acc == ACC_MIN) begin
            acc             <= '0;
            negativeShift_o <= 1'b1;
          end else begin
            acc <= acc - AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PHASE_LOCK_DETECT_EN
  localparam int LW = $clog2(LOCK_COUNT + 1);
  localparam int EW = WW + 1;
  localparam logic [LW-1:0] LOCK_FULL = LW'(LOCK_COUNT);

  logic [EW-1:0] err;
  logic          done;
  logic [LW-1:0] lock_cnt, lock_nxt;

  always_comb begin
    done = (vote != VOTE_NONE) || (state == IDLE && ref_e && fb_e);
    err  = (state == IDLE) ? '0 : ({1'b0, win} + EW'(1));
    lock_nxt = lock_cnt;
    if (done && err <= EW'(LOCK_TOL)) begin
      if (lock_cnt != LOCK_FULL) lock_nxt = lock_cnt + LW'(1);
    end else if (done || timeout) begin
      lock_nxt = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      lock_cnt <= '0;
      lock_o   <= 1'b0;
    end else begin
      lock_cnt <= lock_nxt;
      lock_o   <= (lock_nxt == LOCK_FULL);
    end
  end
`endif

endmodule

// File: tb/tb_phase_shift_ctrl.sv
// Directed bench for phase_shift_ctrl; lock checks compile in with PHASE_LOCK_DETECT_EN.
module tb_phase_shift_ctrl;

  logic clk = 1'b0;
  logic reset_i, ref_i, fb_i;
  logic pos, neg;
`ifdef PHASE_LOCK_DETECT_EN
  logic lock;
`endif

  int vectors = 0;
  int fails   = 0;
  int pos_cnt = 0, neg_cnt = 0, both_cnt = 0, wide_cnt = 0;
  logic pos_q = 1'b0, neg_q = 1'b0;
  logic seen;

  always #5 clk = ~clk;

  phase_shift_ctrl #(.FILTER_N(8), .MAX_WINDOW(64)) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .ref_i(ref_i),
    .fb_i(fb_i),
    .positiveShift_o(pos),
    .negativeShift_o(neg)
`ifdef PHASE_LOCK_DETECT_EN
    ,
    .lock_o(lock)
`endif
  );

  always @(negedge clk) begin
    if (pos === 1'b1) pos_cnt++;
    if (neg === 1'b1) neg_cnt++;
    if (pos === 1'b1 && neg === 1'b1) both_cnt++;
    if ((pos === 1'b1 && pos_q) || (neg === 1'b1 && neg_q)) wide_cnt++;
    pos_q = (pos === 1'b1);
    neg_q = (neg === 1'b1);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 1000000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // lead > 0: ref rises lead cycles before fb; lead < 0: fb first; 0: coincident.
  task automatic pair(input int lead);
    int rs, fs, len;
    rs  = (lead < 0) ? -lead : 0;
    fs  = (lead > 0) ? lead : 0;
    len = rs + fs + 24;
    for (int t = 0; t < len; t++) begin
      ref_i = (t >= rs && t < rs + 8);
      fb_i  = (t >= fs && t < fs + 8);
      @(posedge clk); #1;
    end
    ref_i = 1'b0;
    fb_i  = 1'b0;
  endtask

  task automatic pairs(input int n, input int lead);
    for (int i = 0; i < n; i++) pair(lead);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    reset_i = 1'b1; ref_i = 1'b0; fb_i = 1'b0;
    #3 reset_i = 1'b0;
    #1;
    chk("reset_pos", pos, 0);
    chk("reset_neg", neg, 0);
`ifdef PHASE_LOCK_DETECT_EN
    chk("reset_lock", lock, 0);
`endif
    @(posedge clk); #1 reset_i = 1'b1;
    idle(4);

    // feedback lags by 3
    pairs(7, 3);
    chk("lag_7", pos_cnt, 0);
    pair(3);
    chk("lag_8", pos_cnt, 1);
    pairs(7, 3);
    chk("lag_15", pos_cnt, 1);
    pair(3);
    chk("lag_16", pos_cnt, 2);
    chk("lag_no_neg", neg_cnt, 0);

    // feedback leads by 3
    pairs(7, -3);
    chk("lead_7", neg_cnt, 0);
    pair(-3);
    chk("lead_8", neg_cnt, 1);
    chk("lead_no_pos", pos_cnt, 2);

    // aligned edges
    pairs(15, 0);
`ifdef PHASE_LOCK_DETECT_EN
    chk("lock_15", lock, 0);
`endif
    pair(0);
`ifdef PHASE_LOCK_DETECT_EN
    chk("lock_16", lock, 1);
`endif
    pairs(84, 0);
    chk("aligned_pos", pos_cnt, 2);
    chk("aligned_neg", neg_cnt, 1);
`ifdef PHASE_LOCK_DETECT_EN
    chk("lock_100", lock, 1);
`endif
    pairs(7, 3);
    chk("after_aligned_7", pos_cnt, 2);
`ifdef PHASE_LOCK_DETECT_EN
    chk("lock_drop", lock, 0);
`endif
    pair(3);
    chk("after_aligned_8", pos_cnt, 3);

    // alternating lag / lead
    for (int i = 0; i < 100; i++) begin
      pair(3);
      pair(-3);
    end
    chk("alt_pos", pos_cnt, 3);
    chk("alt_neg", neg_cnt, 1);

    // feedback missing: every window times out
    for (int i = 0; i < 5; i++) begin
      ref_i = 1'b1; idle(8);
      ref_i = 1'b0; idle(90);
    end
    chk("nofb_pos", pos_cnt, 3);
    chk("nofb_neg", neg_cnt, 1);
`ifdef PHASE_LOCK_DETECT_EN
    chk("nofb_lock", lock, 0);
`endif
    pairs(7, 3);
    chk("resume_7", pos_cnt, 3);
    pair(3);
    chk("resume_8", pos_cnt, 4);

    // window boundary: 64 still votes, 65 times out
    pairs(7, 64);
    chk("win64_7", pos_cnt, 4);
    pair(65);
    idle(80);
    chk("win65_novote", pos_cnt, 4);
    pair(64);
    chk("win64_8", pos_cnt, 5);

    // reset with accumulator at +7 loses the votes
    pairs(7, 3);
    chk("pre_rst_7", pos_cnt, 5);
    reset_i = 1'b0; #1;
    chk("rstA_pos", pos, 0);
    chk("rstA_neg", neg, 0);
    @(posedge clk); #1 reset_i = 1'b1;
    idle(4);
    pairs(7, 3);
    chk("post_rst_7", pos_cnt, 5);
    pair(3);
    chk("post_rst_8", pos_cnt, 6);

    // reset asserted while a shift pulse is high
    pairs(7, 3);
    ref_i = 1'b1; idle(3);
    fb_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (pos === 1'b1) seen = 1'b1;
    end
    chk("rstB_pulse_seen", seen, 1);
    reset_i = 1'b0; #1;
    chk("rstB_pos", pos, 0);
    chk("rstB_neg", neg, 0);
`ifdef PHASE_LOCK_DETECT_EN
    chk("rstB_lock", lock, 0);
`endif
    ref_i = 1'b0; fb_i = 1'b0;
    @(posedge clk); #1 reset_i = 1'b1;
    idle(10);
    chk("rstB_no_more", pos_cnt, 7);

    chk("excl_both_high", both_cnt, 0);
    chk("single_cycle_pulses", wide_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
